// File: rtl/row_buffer_sched_pkg.sv
// Shared types and elaboration-time helpers for the row buffer scheduler.
package row_buffer_sched_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Smallest r with 2**r >= v (0 for v <= 1).
    function automatic int clog2_f(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Index width for n entries, never narrower than one bit.
    function automatic int idx_width_f(input int n);
        return (clog2_f(n) < 1) ? 1 : clog2_f(n);
    endfunction

    // Ceiling division for positive operands.
    function automatic int ceil_div_f(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/row_buffer_sched_ring_ptr.sv
// Wrapping pointer into a ring of MODULUS entries; advances by a fixed STEP.
// MODULUS need not be a power of two.
module mod_ring_ptr #(
    parameter int MODULUS = 4,
    parameter int WIDTH   = 2,
    parameter int STEP    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             adv,
    output logic [WIDTH-1:0] ptr
);

    localparam logic [WIDTH:0] MOD_W  = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0] STEP_W = (WIDTH+1)'(STEP);

    logic [WIDTH:0] sum;

    // Next pointer value: one subtraction suffices because STEP < MODULUS.
    always_comb begin
        sum = {1'b0, ptr} + STEP_W;
        if (sum >= MOD_W) sum = sum - MOD_W;
    end

    // Pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      ptr <= '0;
        else if (clr) ptr <= '0;
        else if (adv) ptr <= sum[WIDTH-1:0];
    end

endmodule

// File: rtl/row_buffer_sched.sv
// Row buffer scheduler: hands free physical row buffers to a row writer and
// presents K-row sliding windows to a PE, recycling S buffers per advance.
//
// state   | meaning
// IDLE    | no frame; only start is honoured
// RUN     | frame in progress; writer and PE handshakes active
module row_buffer_sched
    import row_buffer_sched_pkg::*;
#(
    parameter int K          = 3,
    parameter int S          = 1,
    parameter int NUM_ROWS   = 56,
    parameter int ROW_WIDTH  = 10,
    localparam int NBUF      = K + S,
    localparam int IDX_WIDTH = idx_width_f(K + S)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 wr_ready,
    input  logic                 wr_start,
    output logic [IDX_WIDTH-1:0] wr_buf_idx,
    output logic [ROW_WIDTH-1:0] wr_row,
    input  logic                 wr_done,
    output logic                 win_valid,
    output logic [IDX_WIDTH-1:0] win_base_idx,
    output logic [ROW_WIDTH-1:0] win_row,
    input  logic                 pe_buffer_switch,
    output logic                 frame_done,
    output logic                 err
);

    localparam int OCC_W = clog2_f(NBUF + 1);

    state_t               state, state_next;
    logic [OCC_W-1:0]     occ, occ_next;
    logic                 wr_pend;
    logic                 clr, start_acc, wr_fire, wr_acc, sw_acc, sw_final, sw_adv, err_set;

    assign busy      = (state == ST_RUN);
    assign wr_ready  = busy && !wr_pend && (int'(occ) < NBUF) && (int'(wr_row) < NUM_ROWS);
    assign win_valid = busy && (int'(occ) >= K);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next state and handshake qualification; everything except start is dropped in IDLE.
    always_comb begin
        state_next = state;
        start_acc  = 1'b0;
        wr_fire    = 1'b0;
        wr_acc     = 1'b0;
        sw_acc     = 1'b0;
        sw_final   = 1'b0;
        err_set    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    start_acc  = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                wr_fire  = wr_start && wr_ready;
                wr_acc   = wr_done && wr_pend;
                sw_acc   = pe_buffer_switch && win_valid;
                sw_final = sw_acc && (int'(win_row) == NUM_ROWS - K);
                err_set  = (wr_start && !wr_ready) || (wr_done && !wr_pend) ||
                           (pe_buffer_switch && !win_valid);
                if (sw_final) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // A new frame and the end of a frame both return the datapath to row 0.
    assign clr    = start_acc || sw_final;
    assign sw_adv = sw_acc && !sw_final;

    // Occupancy after this cycle's write completion and window release, clamped to 0..NBUF.
    always_comb begin
        int occ_calc;
        occ_calc = int'(occ) + (wr_acc ? 1 : 0) - (sw_adv ? S : 0);
        if (occ_calc < 0)    occ_calc = 0;
        if (occ_calc > NBUF) occ_calc = NBUF;
        occ_next = OCC_W'(occ_calc);
    end

    mod_ring_ptr #(.MODULUS(NBUF), .WIDTH(IDX_WIDTH), .STEP(1)) u_tail (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .adv (wr_acc),
        .ptr (wr_buf_idx)
    );

    mod_ring_ptr #(.MODULUS(NBUF), .WIDTH(IDX_WIDTH), .STEP(S)) u_head (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .adv (sw_adv),
        .ptr (win_base_idx)
    );

    // Row counters, occupancy, writer claim, and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ        <= '0;
            wr_pend    <= 1'b0;
            wr_row     <= '0;
            win_row    <= '0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            frame_done <= sw_final;
            if (start_acc)    err <= 1'b0;
            else if (err_set) err <= 1'b1;
            if (clr) begin
                occ     <= '0;
                wr_pend <= 1'b0;
                wr_row  <= '0;
                win_row <= '0;
            end else begin
                occ <= occ_next;
                if (wr_fire)     wr_pend <= 1'b1;
                else if (wr_acc) wr_pend <= 1'b0;
                if (wr_acc) wr_row  <= wr_row + ROW_WIDTH'(1);
                if (sw_adv) win_row <= win_row + ROW_WIDTH'(S);
            end
        end
    end

endmodule

// File: tb/tb_row_buffer_sched.sv
// Bench for row_buffer_sched with K=3, S=1, NUM_ROWS=5 (NBUF=4).
// The reference model tracks rows written and the window's top row; buffer
// indices and occupancy follow from those by modular arithmetic.
module tb_row_buffer_sched;

    localparam int K    = 3;
    localparam int S    = 1;
    localparam int NR   = 5;
    localparam int RW   = 10;
    localparam int NBUF = K + S;
    localparam int IW   = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, wr_start, wr_done, pe_buffer_switch;
    logic          busy, wr_ready, win_valid, frame_done, err;
    logic [IW-1:0] wr_buf_idx, win_base_idx;
    logic [RW-1:0] wr_row, win_row;

    int vectors     = 0;
    int miscompares = 0;

    bit m_run, m_pend, m_err, m_fd;
    int m_written, m_win_row;

    row_buffer_sched #(.K(K), .S(S), .NUM_ROWS(NR), .ROW_WIDTH(RW)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .busy             (busy),
        .wr_ready         (wr_ready),
        .wr_start         (wr_start),
        .wr_buf_idx       (wr_buf_idx),
        .wr_row           (wr_row),
        .wr_done          (wr_done),
        .win_valid        (win_valid),
        .win_base_idx     (win_base_idx),
        .win_row          (win_row),
        .pe_buffer_switch (pe_buffer_switch),
        .frame_done       (frame_done),
        .err              (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit m_ready();
        return m_run && !m_pend && (m_written - m_win_row) < NBUF && m_written < NR;
    endfunction

    function automatic bit m_valid();
        return m_run && (m_written - m_win_row) >= K;
    endfunction

    task automatic m_clear();
        m_run = 0; m_pend = 0; m_written = 0; m_win_row = 0;
    endtask

    // Advance the model by one clock given this cycle's inputs.
    task automatic m_step(input bit st, input bit ws, input bit wd, input bit sw);
        bit rdy, vld;
        rdy  = m_ready();
        vld  = m_valid();
        m_fd = 0;
        if (!m_run) begin
            if (st) begin
                m_clear();
                m_run = 1;
                m_err = 0;
            end
        end else begin
            if ((ws && !rdy) || (wd && !m_pend) || (sw && !vld)) m_err = 1;
            if (wd && m_pend) begin
                m_pend = 0;
                m_written++;
            end else if (ws && rdy) begin
                m_pend = 1;
            end
            if (sw && vld) begin
                if (m_win_row == NR - K) begin
                    m_clear();
                    m_fd = 1;
                end else begin
                    m_win_row += S;
                end
            end
        end
    endtask

    task automatic check_all(input string ph);
        chk({ph, ".busy"},         busy,         32'(m_run));
        chk({ph, ".wr_ready"},     wr_ready,     32'(m_ready()));
        chk({ph, ".wr_buf_idx"},   wr_buf_idx,   32'(m_written % NBUF));
        chk({ph, ".wr_row"},       wr_row,       32'(m_written));
        chk({ph, ".win_valid"},    win_valid,    32'(m_valid()));
        chk({ph, ".win_base_idx"}, win_base_idx, 32'(m_win_row % NBUF));
        chk({ph, ".win_row"},      win_row,      32'(m_win_row));
        chk({ph, ".frame_done"},   frame_done,   32'(m_fd));
        chk({ph, ".err"},          err,          32'(m_err));
    endtask

    task automatic cycle(input string ph, input bit st, input bit ws, input bit wd, input bit sw);
        start = st; wr_start = ws; wr_done = wd; pe_buffer_switch = sw;
        m_step(st, ws, wd, sw);
        @(posedge clk);
        #1;
        start = 0; wr_start = 0; wr_done = 0; pe_buffer_switch = 0;
        check_all(ph);
    endtask

    task automatic write_row(input string ph);
        cycle({ph, ".claim"}, 0, 1, 0, 0);
        cycle({ph, ".done"},  0, 0, 1, 0);
    endtask

    task automatic check_zero(input string ph);
        chk({ph, ".busy"},         busy,         0);
        chk({ph, ".wr_ready"},     wr_ready,     0);
        chk({ph, ".win_valid"},    win_valid,    0);
        chk({ph, ".frame_done"},   frame_done,   0);
        chk({ph, ".err"},          err,          0);
        chk({ph, ".wr_buf_idx"},   wr_buf_idx,   0);
        chk({ph, ".wr_row"},       wr_row,       0);
        chk({ph, ".win_base_idx"}, win_base_idx, 0);
        chk({ph, ".win_row"},      win_row,      0);
    endtask

    initial begin
        start = 0; wr_start = 0; wr_done = 0; pe_buffer_switch = 0;
        rst = 1;
        m_clear(); m_err = 0; m_fd = 0;
        #2;
        check_zero("por");
        @(posedge clk);
        #1 rst = 0;

        // Frame A: fill, wrap, simultaneous completion and release, finish.
        cycle("a.start", 1, 0, 0, 0);
        write_row("a.r0");
        write_row("a.r1");
        chk("a.pre_valid", win_valid, 0);
        write_row("a.r2");
        chk("a.valid",     win_valid,    1);
        chk("a.win_row0",  win_row,      0);
        chk("a.win_base0", win_base_idx, 0);
        write_row("a.r3");
        chk("a.full_not_ready", wr_ready, 0);
        cycle("a.sw1", 0, 0, 0, 1);
        chk("a.ready_after_sw", wr_ready,     1);
        chk("a.wrap_idx",       wr_buf_idx,   0);
        chk("a.base1",          win_base_idx, 1);
        cycle("a.claim4", 0, 1, 0, 0);
        cycle("a.done_sw", 0, 0, 1, 1);
        chk("a.both_win_row", win_row,   2);
        chk("a.both_valid",   win_valid, 1);
        cycle("a.final", 0, 0, 0, 1);
        chk("a.frame_done", frame_done, 1);
        chk("a.idle_busy",  busy,       0);
        cycle("a.after", 0, 0, 0, 0);
        chk("a.fd_single", frame_done, 0);

        // Idle: stray handshakes are ignored without error.
        cycle("idle.junk", 0, 1, 1, 1);
        chk("idle.no_err", err, 0);

        // Frame B: three window advances, the last one ends the frame.
        cycle("b.start", 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) write_row("b.w");
        cycle("b.sw1", 0, 0, 0, 1);
        write_row("b.w4");
        cycle("b.sw2", 0, 0, 0, 1);
        chk("b.no_fd_yet", frame_done, 0);
        cycle("b.sw3", 0, 0, 0, 1);
        chk("b.fd",    frame_done, 1);
        chk("b.busy",  busy,       0);
        chk("b.valid", win_valid,  0);

        // Frame C: protocol errors, then reset mid-frame.
        cycle("c.start", 1, 0, 0, 0);
        cycle("c.bad_sw", 0, 0, 0, 1);
        chk("c.err_sw",  err,     1);
        chk("c.win_row", win_row, 0);
        cycle("c.bad_done", 0, 0, 1, 0);
        chk("c.wr_row", wr_row, 0);
        write_row("c.r0");
        write_row("c.r1");
        #2 rst = 1;
        m_clear(); m_err = 0; m_fd = 0;
        #1;
        check_zero("c.rst");
        @(posedge clk);
        #1 rst = 0;
        cycle("d.start", 1, 0, 0, 0);
        chk("d.row0", wr_row, 0);
        chk("d.err0", err,    0);

        // Random traffic, including protocol violations and mid-frame starts.
        for (int i = 0; i < 3000; i++) begin
            cycle("rnd",
                  ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 2) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/row_buffer_sched.md
ROW_BUFFER_SCHED -- requirements
Module: row_buffer_sched

Interface
REQ-001 SHALL have parameter K, default 3, conv kernel height (rows per window).
REQ-002 SHALL have parameter S, default 1, row stride (rows released per window advance).
REQ-003 SHALL have parameter NUM_ROWS, default 56, input rows per frame; legal only if NUM_ROWS>=K and (NUM_ROWS-K)%S==0.
REQ-004 SHALL have parameter ROW_WIDTH, default 10, logical row number width.
REQ-005 SHALL derive NBUF=K+S physical row buffers and IDX_WIDTH=max(1,clog2(NBUF)).
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 start  input  1  frame-start pulse; ignored while busy.
REQ-009 busy  output  1  frame in progress.
REQ-010 wr_ready  output  1  a free buffer is available to the writer.
REQ-011 wr_start  input  1  writer claims buffer; fires on wr_start&&wr_ready.
REQ-012 wr_buf_idx  output  IDX_WIDTH  physical buffer to write (tail pointer).
REQ-013 wr_row  output  ROW_WIDTH  logical row the writer must fill.
REQ-014 wr_done  input  1  pulse: claimed buffer fully written.
REQ-015 win_valid  output  1  K consecutive rows resident for the PE.
REQ-016 win_base_idx  output  IDX_WIDTH  physical buffer of window row 0; row k at (base+k) mod NBUF.
REQ-017 win_row  output  ROW_WIDTH  logical top row of current window.
REQ-018 pe_buffer_switch  input  1  pulse: PE finished current window.
REQ-019 frame_done  output  1  one-cycle pulse after final window consumed.
REQ-020 err  output  1  sticky protocol-error flag, cleared by reset or start.

Function
REQ-021 SHALL implement FSM IDLE -> RUN on start; RUN -> IDLE on final switch; busy=1 exactly in RUN.
REQ-022 SHALL keep registers head, tail (mod NBUF), occ (0..NBUF), wr_row, win_row, wr_pend; all cleared on start.
REQ-023 wr_ready SHALL equal RUN && !wr_pend && occ<NBUF && wr_row<NUM_ROWS, combinational from registers.
REQ-024 On wr fire: wr_pend<=1; wr_buf_idx/wr_row hold until wr_done.
REQ-025 On wr_done with wr_pend: wr_pend<=0, tail<=tail+1 mod NBUF, wr_row<=wr_row+1, occ increments.
REQ-026 win_valid SHALL equal RUN && occ>=K; it rises the cycle after the K-th wr_done (1-cycle latency); win_base_idx=head.
REQ-027 On pe_buffer_switch with win_valid, not final window: head<=head+S mod NBUF, win_row<=win_row+S, occ decrements by S.
REQ-028 Final window is win_row==NUM_ROWS-K; switch there SHALL pulse frame_done next cycle, enter IDLE, clear occ/pointers.
REQ-029 Simultaneous wr_done and switch SHALL apply both: occ<=occ+1-S, same cycle.
REQ-030 wr_done without wr_pend, switch with win_valid low, or wr_start while wr_ready low SHALL be ignored and set err.
REQ-031 In IDLE all inputs except start SHALL be ignored without setting err.
REQ-032 occ SHALL never exceed NBUF nor go below 0; all pointer arithmetic wraps modulo NBUF (non-power-of-2 legal).

Reset
REQ-033 On rst asserted, immediately: state=IDLE; busy, wr_ready, win_valid, frame_done, err=0; wr_buf_idx, wr_row, win_base_idx, win_row=0.
REQ-034 Reset mid-frame SHALL abandon the frame; a new start is required.

Structure
REQ-035 Shared package SHALL hold the FSM state enum and the ceil/log2 helper functions.
REQ-036 A single sub-module, mod_ring_ptr (wrapping pointer with advance-by-N), is natural for head and tail.

Verification (K=3,S=1,NUM_ROWS=5,NBUF=4)
REQ-037 start, write rows 0,1,2 -> win_valid=1 cycle after 3rd wr_done, win_row=0, win_base_idx=0.
REQ-038 write 4 rows, no switch -> wr_ready=0; switch -> wr_ready=1 next cycle, wr_buf_idx=0 (wrap), win_base_idx=1.
REQ-039 wr_done and switch same cycle with occ=3 -> occ stays 3, win_row increments by 1.
REQ-040 three switches after all 5 rows -> frame_done single pulse after 3rd, busy=0, win_valid=0.
REQ-041 switch with win_valid=0, or wr_done with no claim -> err=1, counters unchanged.
REQ-042 rst asserted mid-frame (occ=2) -> all outputs 0 without a clock edge; next start resumes from row 0.
